// File: rtl/fsm_dw_core.sv
// Run/done handshake controller: IDLE -> RUN -> DONE -> IDLE, with an optional
// RUN-cycle watchdog that forces completion when the worker never answers.
module fsm_dw_core #(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_run,
    input  logic       i_done,
    output logic       o_done,
    output logic       o_idle,
    output logic       o_running,
    output logic       o_timeout,
    output logic [1:0] o_state
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
    // Counter value seen on the last permitted RUN cycle; only meaningful when the watchdog is on.
    localparam logic [CNT_W-1:0] CNT_LAST =
        WDOG_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             timeout_reg;
    logic             timeout_next;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    // Next-state logic; worker completion wins over the watchdog on the same edge.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        timeout_next = timeout_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_run) begin
                    state_next   = ST_RUN;
                    cnt_next     = '0;
                    timeout_next = 1'b0;
                end
            end
            ST_RUN: begin
                if (i_done) begin
                    state_next   = ST_DONE;
                    timeout_next = 1'b0;
                end else if (WDOG_EN && (cnt_reg == CNT_LAST)) begin
                    state_next   = ST_DONE;
                    timeout_next = 1'b1;
                end else if (!(&cnt_reg)) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Moore outputs; the unused encoding presents itself as IDLE.
    always_comb begin
        o_done    = 1'b0;
        o_idle    = 1'b0;
        o_running = 1'b0;
        o_timeout = 1'b0;
        o_state   = ST_IDLE;
        case (state_reg)
            ST_RUN: begin
                o_running = 1'b1;
                o_state   = ST_RUN;
            end
            ST_DONE: begin
                o_done    = 1'b1;
                o_timeout = timeout_reg;
                o_state   = ST_DONE;
            end
            default: begin
                o_idle  = 1'b1;
                o_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fsm_dw_core.sv
// Bench for fsm_dw_core: one instance with the watchdog off, one with TIMEOUT_CYCLES=4.
module tb_fsm_dw_core;

    typedef struct packed {
        logic   to;
        int     len;
    } exp_t;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] run_v = 2'b00;
    logic [1:0] done_v = 2'b00;
    logic [1:0] o_done_v;
    logic [1:0] o_idle_v;
    logic [1:0] o_running_v;
    logic [1:0] o_timeout_v;
    logic [1:0] st0;
    logic [1:0] st1;

    int n_cmp = 0;
    int n_err = 0;
    exp_t q0[$];
    exp_t q1[$];
    int run_len [2];

    fsm_dw_core u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .i_run     (run_v[0]),
        .i_done    (done_v[0]),
        .o_done    (o_done_v[0]),
        .o_idle    (o_idle_v[0]),
        .o_running (o_running_v[0]),
        .o_timeout (o_timeout_v[0]),
        .o_state   (st0)
    );

    fsm_dw_core #(.TIMEOUT_CYCLES(4), .CNT_W(16)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .i_run     (run_v[1]),
        .i_done    (done_v[1]),
        .o_done    (o_done_v[1]),
        .o_idle    (o_idle_v[1]),
        .o_running (o_running_v[1]),
        .o_timeout (o_timeout_v[1]),
        .o_state   (st1)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, need %0h", name, act, req);
        end
    endtask

    function automatic logic [1:0] state_of(input int d);
        return (d == 0) ? st0 : st1;
    endfunction

    // Pulse the selected inputs across exactly one rising edge.
    task automatic drive(input logic [1:0] r, input logic [1:0] dn);
        run_v  = r;
        done_v = dn;
        @(posedge clk);
        #1;
        run_v  = 2'b00;
        done_v = 2'b00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_idle_all(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_idle"},    {31'd0, o_idle_v[d]},    32'd1);
            chk({tag, "_done"},    {31'd0, o_done_v[d]},    32'd0);
            chk({tag, "_running"}, {31'd0, o_running_v[d]}, 32'd0);
            chk({tag, "_timeout"}, {31'd0, o_timeout_v[d]}, 32'd0);
            chk({tag, "_state"},   {30'd0, state_of(d)},    32'd0);
        end
    endtask

    // Monitor: measures each run and checks every completion against the queue.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                run_len[d] = 0;
            end else begin
                if (o_running_v[d]) run_len[d] = run_len[d] + 1;
                if (!o_done_v[d]) begin
                    chk($sformatf("timeout_outside_done%0d", d), {31'd0, o_timeout_v[d]}, 32'd0);
                end else begin
                    exp_t e;
                    logic have;
                    have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
                    chk($sformatf("expected_done%0d", d), {31'd0, have}, 32'd1);
                    if (have) begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        $display("dut%0d completion: run_len=%0d timeout=%0b (want %0d/%0b)",
                                 d, run_len[d], o_timeout_v[d], e.len, e.to);
                        chk($sformatf("run_len%0d", d), run_len[d], e.len);
                        chk($sformatf("timeout%0d", d), {31'd0, o_timeout_v[d]}, {31'd0, e.to});
                        chk($sformatf("done_state%0d", d), {30'd0, state_of(d)}, 32'd2);
                        chk($sformatf("done_idle%0d", d), {31'd0, o_idle_v[d]}, 32'd0);
                    end
                    run_len[d] = 0;
                end
            end
        end
    end

    initial begin
        run_len[0] = 0;
        run_len[1] = 0;

        // Asynchronous reset with the clock stopped.
        #1 reset = 1'b1;
        #10;
        chk_idle_all("rst_hold");
        reset = 1'b0;
        #2;
        chk_idle_all("rst_release");
        clk_en = 1'b1;
        idle(2);

        // Nominal handshake on dut0: RUN for 2 cycles.
        q0.push_back('{to: 1'b0, len: 2});
        drive(2'b01, 2'b00);
        chk("nominal_run_state", {30'd0, st0}, 32'd1);
        idle(1);
        drive(2'b00, 2'b01);
        chk("nominal_done_state", {30'd0, st0}, 32'd2);
        idle(1);
        chk("nominal_back_idle", {30'd0, st0}, 32'd0);

        // i_done in IDLE is ignored.
        drive(2'b00, 2'b01);
        chk("done_in_idle", {30'd0, st0}, 32'd0);

        // Simultaneous run+done in IDLE starts a run; repeat i_run in RUN ignored.
        q0.push_back('{to: 1'b0, len: 2});
        drive(2'b01, 2'b01);
        chk("run_and_done_idle", {30'd0, st0}, 32'd1);
        drive(2'b01, 2'b00);
        chk("run_in_run", {30'd0, st0}, 32'd1);
        drive(2'b00, 2'b01);
        // i_run on the edge leaving DONE is dropped; the next one is accepted.
        drive(2'b01, 2'b00);
        chk("run_in_done_dropped", {30'd0, st0}, 32'd0);
        q0.push_back('{to: 1'b0, len: 1});
        drive(2'b01, 2'b00);
        chk("run_after_done", {30'd0, st0}, 32'd1);
        drive(2'b00, 2'b01);
        idle(1);

        // Watchdog disabled: a long run waits for the worker.
        q0.push_back('{to: 1'b0, len: 11});
        drive(2'b01, 2'b00);
        idle(10);
        chk("no_watchdog_running", {31'd0, o_running_v[0]}, 32'd1);
        drive(2'b00, 2'b01);
        idle(2);

        // Watchdog fires after exactly 4 RUN cycles.
        q1.push_back('{to: 1'b1, len: 4});
        drive(2'b10, 2'b00);
        idle(3);
        chk("wdog_still_run", {30'd0, st1}, 32'd1);
        idle(1);
        chk("wdog_done_state", {30'd0, st1}, 32'd2);
        idle(1);
        chk("wdog_back_idle", {30'd0, st1}, 32'd0);
        idle(1);

        // i_done on the 4th RUN cycle beats the watchdog.
        q1.push_back('{to: 1'b0, len: 4});
        drive(2'b10, 2'b00);
        idle(3);
        drive(2'b00, 2'b10);
        idle(2);

        // Reset mid-RUN on both instances: immediate IDLE, no completion follows.
        drive(2'b11, 2'b00);
        idle(1);
        #2 reset = 1'b1;
        #1;
        chk_idle_all("rst_midrun");
        #4 reset = 1'b0;
        idle(8);
        chk("rst_midrun_stays_idle0", {30'd0, st0}, 32'd0);
        chk("rst_midrun_stays_idle1", {30'd0, st1}, 32'd0);

        chk("pending_q0", q0.size(), 32'd0);
        chk("pending_q1", q1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fsm_dw_core.md
Name:
fsm_dw_core

Overview:
- Three-state run/done handshake controller (IDLE -> RUN -> DONE -> IDLE).
- Sits between a command source (one-cycle `i_run` start pulse) and a datapath worker (one-cycle `i_done` completion pulse).
- Produces a one-cycle `o_done` completion strobe back to the command source, plus status outputs.
- Optional watchdog forces completion if the worker never answers.

Parameters:
- TIMEOUT_CYCLES, default 0: max cycles spent in RUN before forced completion. 0 = watchdog disabled.
- CNT_W, default 16: width of the RUN-cycle counter. TIMEOUT_CYCLES must be < 2**CNT_W.

Ports:
- clk  input  1  rising-edge system clock.
- reset  input  1  asynchronous reset, active-high.
- i_run  input  1  start request, sampled in IDLE only.
- i_done  input  1  worker completion, sampled in RUN only.
- o_done  output  1  completion strobe, high exactly one cycle (state DONE).
- o_idle  output  1  high while state = IDLE.
- o_running  output  1  high while state = RUN.
- o_timeout  output  1  high during DONE when completion was forced by the watchdog.
- o_state  output  2  encoded state: IDLE=2'b00, RUN=2'b01, DONE=2'b10 (2'b11 unused).

Behaviour:
- Reset: one clock, `clk`; `reset` asynchronous, active-high.
  - While `reset`=1: state=IDLE, counter=0, timeout flag=0.
  - Outputs during reset: `o_idle`=1, `o_done`=0, `o_running`=0, `o_timeout`=0, `o_state`=00.
  - Reset asserted mid-RUN or mid-DONE returns to IDLE immediately, without waiting for a clock edge. A pending completion is discarded and no `o_done` is emitted.
- State register updates on rising `clk`. All outputs are Moore: decoded from registered state and flag only, never combinationally from inputs.
- IDLE:
  - `i_run`=1 at an edge -> RUN next cycle, counter cleared to 0.
  - `i_done` is ignored in IDLE.
  - `i_run` and `i_done` both high -> RUN; `i_done` is ignored.
- RUN:
  - `i_done`=1 at an edge -> DONE next cycle, timeout flag=0.
  - Otherwise, if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1 -> DONE, timeout flag=1.
  - Otherwise stay in RUN, counter += 1, saturating at all-ones.
  - `i_done` takes priority over the watchdog on the same edge.
  - `i_run` is ignored in RUN; no restart, no queueing.
- DONE:
  - Lasts exactly one cycle with `o_done`=1, then unconditionally -> IDLE.
  - `i_run`/`i_done` ignored in DONE.
  - `o_timeout` mirrors the flag during DONE only; it is 0 in all other states.
  - A new `i_run` is accepted only once back in IDLE, i.e. at the first edge after DONE.
- Latency:
  - `i_run` sampled at edge N -> `o_running` high from edge N.
  - `i_done` sampled at edge M -> `o_done` high from edge M for one cycle.
- Unused encoding 2'b11: next state = IDLE, outputs as IDLE.
- Inputs are synchronous to `clk`; no input synchronizers inside the block.

Test Plan:
- Reset sequence: hold `reset`=1 for 10 ns with no clock edge -> `o_idle`=1, `o_done`=0, `o_state`=00 immediately. Release -> unchanged.
- Nominal handshake: `i_run` pulse 1 cycle, idle 1 cycle, `i_done` pulse 1 cycle -> `o_state` 00 -> 01 (2 cycles) -> 10 (1 cycle, `o_done`=1, `o_timeout`=0) -> 00.
- Ignored inputs:
  - `i_done` pulses in IDLE -> no state change.
  - `i_run` pulses during RUN -> stay in RUN.
  - After DONE, the block is in IDLE and accepts the next `i_run`.
- Watchdog: TIMEOUT_CYCLES=4, `i_run` pulse, no `i_done` -> RUN for exactly 4 cycles, then DONE with `o_done`=1 and `o_timeout`=1 for 1 cycle, then IDLE.
- Priority at timeout: TIMEOUT_CYCLES=4, `i_done` on the 4th RUN cycle -> DONE with `o_timeout`=0.
- Reset mid-operation: assert `reset` during RUN between edges -> immediate IDLE, no `o_done` pulse ever appears for that run.
